// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data load/store.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT contested data wins.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_cs,
  output logic        mem_wen,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

  state_e        state_q;
  logic          owner_if_q;
  logic [SW-1:0] starve_q, starve_d;
  logic [3:0]    wcnt_q;
  logic          mem_cs_q, mem_wen_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic          if_rvalid_q, d_rvalid_q;
  logic [31:0]   if_rdata_q, d_rdata_q;
  logic          idle, resp, d_win;

  assign idle = (state_q == S_IDLE);
  assign resp = (state_q == S_RESP);

  always_comb begin
    d_win  = d_req && (!if_req || (starve_q < SW'(STARVE_LIMIT)));
    d_gnt  = RSTn && idle && d_win;
    if_gnt = RSTn && idle && if_req && !d_win;
    starve_d = starve_q;
    if (if_gnt)
      starve_d = '0;
    else if (d_gnt && if_req)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      owner_if_q  <= 1'b0;
      starve_q    <= '0;
      wcnt_q      <= '0;
      mem_cs_q    <= 1'b0;
      mem_wen_q   <= 1'b1;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (if_gnt || d_gnt) begin
            state_q     <= S_ACCESS;
            owner_if_q  <= if_gnt;
            starve_q    <= starve_d;
            mem_cs_q    <= 1'b1;
            mem_wen_q   <= if_gnt ? 1'b1 : d_wen;
            mem_be_q    <= if_gnt ? 4'b1111 : d_be;
            mem_addr_q  <= if_gnt ? if_addr : d_addr;
            mem_wdata_q <= if_gnt ? '0 : d_wdata;
          end
        end
        S_ACCESS: begin
          mem_cs_q <= 1'b0;
          wcnt_q   <= 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_q     <= S_RESP;
            if_rvalid_q <= owner_if_q;
            d_rvalid_q  <= !owner_if_q;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_q     <= S_RESP;
            if_rvalid_q <= owner_if_q;
            d_rvalid_q  <= !owner_if_q;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          if (owner_if_q)
            if_rdata_q <= mem_rdata;
          else
            d_rdata_q <= mem_wen_q ? mem_rdata : '0;
          mem_wen_q   <= 1'b1;
          mem_be_q    <= '0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
      endcase
    end
  end

  // Read data passes straight through during RESP; the held copy covers every other cycle.
  assign if_rdata  = (resp && owner_if_q) ? mem_rdata : if_rdata_q;
  assign d_rdata   = (resp && !owner_if_q) ? (mem_wen_q ? mem_rdata : '0) : d_rdata_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign mem_cs    = mem_cs_q;
  assign mem_wen   = mem_wen_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = !idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_CYCLES=2/STARVE_LIMIT=4 and 0/2),
// directed scenarios with literal expectations plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  logic        if_req[2], if_gnt[2], if_rvalid[2];
  logic [31:0] if_addr[2], if_rdata[2];
  logic        d_req[2], d_wen[2], d_gnt[2], d_rvalid[2];
  logic [3:0]  d_be[2];
  logic [31:0] d_addr[2], d_wdata[2], d_rdata[2];
  logic        mem_cs[2], mem_wen[2], busy[2];
  logic [3:0]  mem_be[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];

  mem_port_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(4)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_wen(d_wen[0]), .d_be(d_be[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_cs(mem_cs[0]), .mem_wen(mem_wen[0]), .mem_be(mem_be[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(2)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_wen(d_wen[1]), .d_be(d_be[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_cs(mem_cs[1]), .mem_wen(mem_wen[1]), .mem_be(mem_be[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
  endtask

  // Transaction-level model: an access is "k cycles since its grant"; mem_cs at k=1, response at k=2+W.
  int          Wp[2] = '{2, 0};
  int          Lp[2] = '{4, 2};
  bit          m_act[2];
  int          m_k[2], m_starve[2];
  bit          m_own_f[2];
  logic        m_wen[2];
  logic [3:0]  m_be[2];
  logic [31:0] m_addr[2], m_wd[2], m_ifh[2], m_dh[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_starve[i] = 0; m_own_f[i] = 0;
      m_wen[i] = 1; m_be[i] = 0; m_addr[i] = 0; m_wd[i] = 0; m_ifh[i] = 0; m_dh[i] = 0;
    end
  end

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      string p;
      bit take_d, take_f, last;
      logic e_ifv, e_dv, e_cs, e_wen, e_busy;
      logic [3:0] e_be;
      logic [31:0] e_addr, e_wd, e_ifr, e_dr;
      p = $sformatf("dut%0d", i);
      if (!RSTn) begin
        chk({p, " if_gnt(rst)"}, if_gnt[i], 0);
        chk({p, " d_gnt(rst)"}, d_gnt[i], 0);
        m_act[i] = 0; m_starve[i] = 0; m_ifh[i] = 0; m_dh[i] = 0;
      end else begin
        take_d = 0; take_f = 0; last = 0;
        if (!m_act[i]) begin
          take_d = d_req[i] && (!if_req[i] || m_starve[i] < Lp[i]);
          take_f = if_req[i] && !take_d;
          e_busy = 0; e_cs = 0; e_wen = 1; e_be = 0; e_addr = 0; e_wd = 0;
          e_ifv = 0; e_dv = 0; e_ifr = m_ifh[i]; e_dr = m_dh[i];
        end else begin
          last = (m_k[i] == 2 + Wp[i]);
          e_busy = 1; e_cs = (m_k[i] == 1); e_wen = m_wen[i]; e_be = m_be[i];
          e_addr = m_addr[i]; e_wd = m_wd[i];
          e_ifv = last && m_own_f[i];
          e_dv  = last && !m_own_f[i];
          e_ifr = e_ifv ? mem_rdata[i] : m_ifh[i];
          e_dr  = e_dv ? (m_wen[i] ? mem_rdata[i] : 32'h0) : m_dh[i];
        end
        chk({p, " if_gnt"}, if_gnt[i], take_f);
        chk({p, " d_gnt"}, d_gnt[i], take_d);
        chk({p, " busy"}, busy[i], e_busy);
        chk({p, " mem_cs"}, mem_cs[i], e_cs);
        chk({p, " mem_wen"}, mem_wen[i], e_wen);
        chk({p, " mem_be"}, mem_be[i], e_be);
        chk({p, " mem_addr"}, mem_addr[i], e_addr);
        chk({p, " mem_wdata"}, mem_wdata[i], e_wd);
        chk({p, " if_rvalid"}, if_rvalid[i], e_ifv);
        chk({p, " d_rvalid"}, d_rvalid[i], e_dv);
        chk({p, " if_rdata"}, if_rdata[i], e_ifr);
        chk({p, " d_rdata"}, d_rdata[i], e_dr);
        if (take_d || take_f) begin
          m_act[i] = 1; m_k[i] = 1; m_own_f[i] = take_f;
          m_wen[i]  = take_f ? 1'b1 : d_wen[i];
          m_be[i]   = take_f ? 4'hF : d_be[i];
          m_addr[i] = take_f ? if_addr[i] : d_addr[i];
          m_wd[i]   = take_f ? 32'h0 : d_wdata[i];
          if (take_f) m_starve[i] = 0;
          else if (if_req[i]) m_starve[i]++;
        end else if (m_act[i]) begin
          if (last) begin
            m_act[i] = 0;
            m_ifh[i] = e_ifr;
            m_dh[i]  = e_dr;
          end else m_k[i]++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 40) begin
      neg();
      n++;
    end
    chk($sformatf("dut%0d wait_idle", i), busy[i], 0);
  endtask

  initial begin #1000000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

  initial begin
    logic [9:0] seq;
    int gcnt;
    logic rv;
    bit gs_if[2], gs_d[2];

    RSTn = 0;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 0; if_addr[i] = 0; d_req[i] = 0; d_wen[i] = 1; d_be[i] = 0;
      d_addr[i] = 0; d_wdata[i] = 0; mem_rdata[i] = 0; gs_if[i] = 0; gs_d[i] = 0;
    end
    repeat (3) cyc();
    neg();
    chk("reset busy", busy[0], 0);
    chk("reset mem_wen", mem_wen[0], 1);
    chk("reset mem_cs", mem_cs[0], 0);
    chk("reset if_rdata", if_rdata[0], 0);
    cyc();
    RSTn = 1;

    // Fetch, WAIT_CYCLES=2
    if_req[0] = 1; if_addr[0] = 32'h100; mem_rdata[0] = 32'h00500093;
    neg(); chk("fetch if_gnt@T", if_gnt[0], 1);
    cyc(); if_req[0] = 0;
    neg(); chk("fetch mem_cs@T+1", mem_cs[0], 1); chk("fetch mem_addr", mem_addr[0], 32'h100);
    cyc(); cyc(); cyc();
    neg(); chk("fetch if_rvalid@T+4", if_rvalid[0], 1); chk("fetch if_rdata", if_rdata[0], 32'h00500093);
    wait_idle(0);

    // Store
    cyc();
    d_req[0] = 1; d_wen[0] = 0; d_be[0] = 4'b0011; d_addr[0] = 32'h2000; d_wdata[0] = 32'hDEADBEEF;
    neg(); chk("store d_gnt@T", d_gnt[0], 1);
    cyc(); d_req[0] = 0;
    neg(); chk("store mem_cs", mem_cs[0], 1); chk("store mem_wen", mem_wen[0], 0);
    chk("store mem_be", mem_be[0], 4'b0011); chk("store mem_wdata", mem_wdata[0], 32'hDEADBEEF);
    cyc(); cyc(); cyc();
    neg(); chk("store d_rvalid@T+4", d_rvalid[0], 1); chk("store d_rdata", d_rdata[0], 0);
    wait_idle(0);

    // Both held continuously: expect D,D,D,D,F,D,D,D,D,F
    cyc();
    if_req[0] = 1; if_addr[0] = 32'h140; d_req[0] = 1; d_wen[0] = 1; d_be[0] = 4'hF; d_addr[0] = 32'h3000;
    seq = '0; gcnt = 0;
    for (int n = 0; n < 200 && gcnt < 10; n++) begin
      neg();
      if (if_gnt[0]) begin seq = {seq[8:0], 1'b1}; gcnt++; end
      else if (d_gnt[0]) begin seq = {seq[8:0], 1'b0}; gcnt++; end
      cyc();
    end
    if_req[0] = 0; d_req[0] = 0;
    chk("starve grant count", gcnt, 10);
    chk("starve grant order", seq, 10'b0000100001);
    wait_idle(0);

    // Data request raised during a fetch's WAIT
    cyc();
    if_req[0] = 1; if_addr[0] = 32'h300;
    neg(); chk("dwait if_gnt@T", if_gnt[0], 1);
    cyc(); if_req[0] = 0;
    cyc(); d_req[0] = 1; d_wen[0] = 1; d_be[0] = 4'hF; d_addr[0] = 32'h400;
    neg(); chk("dwait d_gnt@T+2", d_gnt[0], 0);
    cyc(); neg(); chk("dwait d_gnt@T+3", d_gnt[0], 0);
    cyc(); neg(); chk("dwait if_rvalid@T+4", if_rvalid[0], 1); chk("dwait d_gnt@T+4", d_gnt[0], 0);
    cyc(); neg(); chk("dwait d_gnt@T+5", d_gnt[0], 1);
    cyc(); d_req[0] = 0;
    wait_idle(0);

    // Reset during WAIT aborts the access
    cyc();
    if_req[0] = 1; if_addr[0] = 32'h500;
    neg(); chk("abort if_gnt@T", if_gnt[0], 1);
    cyc(); if_req[0] = 0;
    cyc(); RSTn = 0;
    cyc(); RSTn = 1;
    neg(); chk("abort busy", busy[0], 0); chk("abort mem_wen", mem_wen[0], 1); chk("abort mem_cs", mem_cs[0], 0);
    rv = 0;
    repeat (6) begin cyc(); neg(); rv = rv | if_rvalid[0]; end
    chk("abort no if_rvalid", rv, 0);

    // WAIT_CYCLES=0 instance, back-to-back reads
    cyc();
    d_req[1] = 1; d_wen[1] = 1; d_be[1] = 4'hF; d_addr[1] = 32'h600; mem_rdata[1] = 32'h12345678;
    neg(); chk("w0 d_gnt@T", d_gnt[1], 1);
    cyc(); neg(); chk("w0 mem_cs@T+1", mem_cs[1], 1); chk("w0 d_gnt@T+1", d_gnt[1], 0);
    cyc(); neg(); chk("w0 d_rvalid@T+2", d_rvalid[1], 1); chk("w0 d_rdata", d_rdata[1], 32'h12345678);
    chk("w0 d_gnt@T+2", d_gnt[1], 0);
    cyc(); neg(); chk("w0 d_gnt@T+3", d_gnt[1], 1);
    cyc(); d_req[1] = 0;
    wait_idle(1);

    // Random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      cyc();
      RSTn = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 2; i++) begin
        if (gs_if[i]) if_req[i] = 0;
        if (gs_d[i]) d_req[i] = 0;
        if (!if_req[i] && $urandom_range(0, 2) == 0) begin
          if_req[i] = 1; if_addr[i] = $urandom;
        end
        if (!d_req[i] && $urandom_range(0, 2) == 0) begin
          d_req[i] = 1; d_wen[i] = $urandom_range(0, 1); d_be[i] = 4'($urandom);
          d_addr[i] = $urandom; d_wdata[i] = $urandom;
        end
        mem_rdata[i] = $urandom;
      end
      neg();
      for (int i = 0; i < 2; i++) begin
        gs_if[i] = if_gnt[i];
        gs_d[i]  = d_gnt[i];
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
